// File: rtl/snap_phase_capture_if.sv
// Bundles the phase sample stream into the capture block and the BRAM write port out of it.
// master = the capture block, slave = the sample source / BRAM side.
interface snap_phase_capture_if #(
    parameter int ADDR_W  = 10,
    parameter int PHASE_W = 16
);
    logic [PHASE_W-1:0] phase_in;
    logic [7:0]         chan_in;
    logic               phase_valid;
    logic [ADDR_W-1:0]  bram_addr;
    logic [31:0]        bram_data;
    logic               bram_we;

    modport master (
        input  phase_in, chan_in, phase_valid,
        output bram_addr, bram_data, bram_we
    );

    modport slave (
        output phase_in, chan_in, phase_valid,
        input  bram_addr, bram_data, bram_we
    );
endinterface

// File: rtl/snap_phase_capture.sv
// Snapshot of one channel's phase samples into BRAM, armed by a PPC control word.
// Define SNAP_PHASE_TIMESTAMP_EN to store {timestamp, phase} per sample instead of phase pairs.
module snap_phase_capture #(
    parameter int ADDR_W  = 10,
    parameter int PHASE_W = 16
) (
    input  logic                 user_clk,
    input  logic                 user_rst,
    input  logic [31:0]          ctrl_in,
    output logic [31:0]          status_out,
    snap_phase_capture_if.master bus
);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t             state_reg;
    state_t             state_next;
    logic               arm_d_reg;
    logic               arm_block_reg;
    logic               arm_edge;
    logic [7:0]         chan_reg;
    logic [9:0]         len_reg;
    logic [10:0]        words_written_reg;
    logic [10:0]        words_eff;
    logic [ADDR_W-1:0]  bram_addr_reg;
    logic [31:0]        bram_data_reg;
    logic               bram_we_reg;
    logic               last_write;
    logic               start;
    logic               accept;
    logic               busy;
    logic               done;
    logic               unused_ctrl;

    assign unused_ctrl = ^{ctrl_in[31:26], ctrl_in[7:1]};

    // A reset leaves the arm blocked until it has been seen low, so a held arm cannot restart.
    assign arm_edge   = ctrl_in[0] & ~arm_d_reg & ~arm_block_reg;
    assign last_write = bram_we_reg && (words_written_reg == {1'b0, len_reg});
    // Count that the next write will land on, including a write in flight this cycle.
    assign words_eff  = words_written_reg + {10'd0, bram_we_reg};

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (arm_edge)   state_next = CAPTURE;
            CAPTURE: if (last_write) state_next = DONE;
            DONE:    if (!arm_d_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_reg == CAPTURE);
        done   = (state_reg == DONE);
        start  = (state_reg == IDLE) && arm_edge;
        // Nothing is accepted while the final word is on the bus.
        accept = busy && bus.phase_valid && (bus.chan_in == chan_reg) && !last_write;
    end

`ifdef SNAP_PHASE_TIMESTAMP_EN
    logic [15:0] ts_reg;

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            ts_reg <= 16'd0;
        end else begin
            ts_reg <= ts_reg + 16'd1;
        end
    end
`else
    logic half_reg;
`endif

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            arm_d_reg         <= 1'b0;
            arm_block_reg     <= 1'b1;
            chan_reg          <= 8'd0;
            len_reg           <= 10'd0;
            words_written_reg <= 11'd0;
            bram_addr_reg     <= '0;
            bram_data_reg     <= 32'd0;
            bram_we_reg       <= 1'b0;
`ifndef SNAP_PHASE_TIMESTAMP_EN
            half_reg          <= 1'b0;
`endif
        end else begin
            arm_d_reg   <= ctrl_in[0];
            bram_we_reg <= 1'b0;
            if (!ctrl_in[0]) begin
                arm_block_reg <= 1'b0;
            end
            if (bram_we_reg) begin
                words_written_reg <= words_written_reg + 11'd1;
            end
            if (start) begin
                chan_reg          <= ctrl_in[15:8];
                len_reg           <= ctrl_in[25:16];
                words_written_reg <= 11'd0;
`ifndef SNAP_PHASE_TIMESTAMP_EN
                half_reg          <= 1'b0;
`endif
            end
            if (accept) begin
`ifdef SNAP_PHASE_TIMESTAMP_EN
                bram_data_reg <= {ts_reg, bus.phase_in};
                bram_we_reg   <= 1'b1;
                bram_addr_reg <= ADDR_W'(words_eff);
`else
                if (!half_reg) begin
                    bram_data_reg[31:16] <= bus.phase_in;
                    half_reg             <= 1'b1;
                end else begin
                    bram_data_reg[15:0] <= bus.phase_in;
                    half_reg            <= 1'b0;
                    bram_we_reg         <= 1'b1;
                    bram_addr_reg       <= ADDR_W'(words_eff);
                end
`endif
            end
        end
    end

    assign bus.bram_addr = bram_addr_reg;
    assign bus.bram_data = bram_data_reg;
    assign bus.bram_we   = bram_we_reg;
    assign status_out    = {done, busy, 19'd0, words_written_reg};

endmodule
